// File: rtl/cpa_pipe_2stage.sv
// ---------------------------------------------------------------------------------------------
// cpa_pipe_2stage
//
// Final carry-propagate adder behind a partial-product reduction tree. The tree hands over a
// SUM row (bit i at weight i) and a CARRY row (bit i at weight i+1). This block shifts the
// CARRY row into place, adds the two rows in a two-stage split adder and delivers the product
// word through a valid/ready handshake.
//
//   Stage 1 adds the low SPLIT bits, registers the partial sum and its carry, and forwards
//           the untouched upper operand slices.
//   Stage 2 adds the upper slices plus the stage-1 carry and registers the full result.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   sum_row / carry_row valid
//   in_ready   out  block accepts input this cycle
//   sum_row    in   [WIDTH] SUM row, bit i at weight i
//   carry_row  in   [WIDTH] CARRY row, bit i at weight i+1 (unshifted)
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   result     out  [WIDTH] (sum_row + (carry_row << 1)) mod 2^WIDTH
//   cout       out  carry out of bit WIDTH-1 of that addition
//
// Parameters
//   WIDTH  row and result width in bits
//   SPLIT  number of low-order bits added in stage 1, legal range 1..WIDTH-1
// ---------------------------------------------------------------------------------------------
module cpa_pipe_2stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SPLIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_row,
    input  logic [WIDTH-1:0] carry_row,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int unsigned HI_W = WIDTH - SPLIT;

    // Reject an illegal split at elaboration rather than building a malformed adder.
    generate
        if (SPLIT < 1 || SPLIT > WIDTH - 1) begin : g_bad_split
            $error("cpa_pipe_2stage: SPLIT must lie in 1..WIDTH-1");
        end
    endgenerate

    // -----------------------------------------------------------------------------------------
    // Operand formation
    // -----------------------------------------------------------------------------------------
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    // The top CARRY bit would land at weight WIDTH; the tree's own shift truncates it too.
    logic unused_carry_msb;
    assign unused_carry_msb = carry_row[WIDTH-1];

    assign op_a = sum_row;
    assign op_b = {carry_row[WIDTH-2:0], 1'b0};

    // -----------------------------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------------------------
    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic s2_en;
    logic accept;

    // Stage 2 may load when it is empty or its contents leave this cycle.
    assign s2_en    = v1_q & (~v2_q | out_ready);
    // Depends on out_ready but never on in_valid.
    assign in_ready = ~v1_q | s2_en;
    assign accept   = in_valid & in_ready;

    always_comb begin
        v1_d = v1_q;
        if (accept) begin
            v1_d = 1'b1;
        end else if (s2_en) begin
            v1_d = 1'b0;
        end
    end

    always_comb begin
        v2_d = v2_q;
        if (s2_en) begin
            v2_d = 1'b1;
        end else if (out_ready) begin
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Stage 1: low-slice add, upper slices forwarded
    // -----------------------------------------------------------------------------------------
    logic [SPLIT:0]     lo_sum;
    logic [SPLIT-1:0]   lo_q;
    logic               c_mid_q;
    logic [HI_W-1:0]    a_hi_q;
    logic [HI_W-1:0]    b_hi_q;

    assign lo_sum = {1'b0, op_a[SPLIT-1:0]} + {1'b0, op_b[SPLIT-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q    <= '0;
            c_mid_q <= 1'b0;
            a_hi_q  <= '0;
            b_hi_q  <= '0;
        end else if (accept) begin
            lo_q    <= lo_sum[SPLIT-1:0];
            c_mid_q <= lo_sum[SPLIT];
            a_hi_q  <= op_a[WIDTH-1:SPLIT];
            b_hi_q  <= op_b[WIDTH-1:SPLIT];
        end
    end

    // -----------------------------------------------------------------------------------------
    // Stage 2: high-slice add with the carry from stage 1
    // -----------------------------------------------------------------------------------------
    logic [HI_W:0]      hi_sum;
    logic [WIDTH-1:0]   result_q;
    logic               cout_q;

    assign hi_sum = {1'b0, a_hi_q} + {1'b0, b_hi_q} + {{HI_W{1'b0}}, c_mid_q};

    // Loads only on s2_en, so a stalled result holds and reset zeros never go X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            cout_q   <= 1'b0;
        end else if (s2_en) begin
            result_q <= {hi_sum[HI_W-1:0], lo_q};
            cout_q   <= hi_sum[HI_W];
        end
    end

    assign out_valid = v2_q;
    assign result    = result_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_cpa_pipe_2stage.sv
// Scoreboard bench for cpa_pipe_2stage: the driver pushes expected results on accept, an
// independent monitor pops and compares whenever a result is handed downstream.
module tb_cpa_pipe_2stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] sum_row;
    logic [31:0] carry_row;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        cout;

    always #5 clk = ~clk;

    cpa_pipe_2stage #(
        .WIDTH (32),
        .SPLIT (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_row   (sum_row),
        .carry_row (carry_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout)
    );

    typedef struct {
        logic [31:0] res;
        logic        co;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int retries = 0;
    bit saw_block = 0;

    bit stall_on   = 0;
    bit hold_stall = 0;
    int stall_from = 0;
    int stall_to   = 0;

    bit          head_seen    = 0;
    bit          stalled_prev = 0;
    logic [31:0] prev_res;
    logic        prev_co;
    bit          mon_fire;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: the rows represent the value sum + 2*carry, with the carry bit that would sit
    // at weight 2^32 dropped; bit 32 of that value is the carry out.
    function automatic logic ref_cout(input logic [31:0] s, input logic [31:0] c);
        longint unsigned t;
        t = longint'(s) + 2 * (longint'(c) % 64'h8000_0000);
        return t[32];
    endfunction

    function automatic logic [31:0] ref_value(input logic [31:0] s, input logic [31:0] c);
        longint unsigned t;
        t = longint'(s) + 2 * (longint'(c) % 64'h8000_0000);
        return t[31:0];
    endfunction

    task automatic drive_or();
        out_ready = !(hold_stall || (stall_on && cyc >= stall_from && cyc <= stall_to));
    endtask

    task automatic send(input logic [31:0] s, input logic [31:0] c, input logic [31:0] er,
                        input logic eco, input bit lat);
        bit   fired;
        int   tries;
        exp_t e;
        fired = 0;
        tries = 0;
        while (!fired) begin
            @(negedge clk);
            in_valid  = 1'b1;
            sum_row   = s;
            carry_row = c;
            drive_or();
            #2;
            // Two in flight and no drain is the only condition that may block input.
            check("in_ready_vs_occupancy", in_ready, !(sb.size() == 2 && !out_ready));
            check("occupancy_le_2", sb.size() <= 2, 1);
            fired = in_ready;
            if (!in_ready) saw_block = 1;
            e.res = er;
            e.co  = eco;
            e.acc = cyc;
            e.lat = lat;
            @(posedge clk);
            if (fired) sb.push_back(e);
            else retries++;
            tries++;
            if (!fired && tries > 200) begin
                check("send_timeout", 0, 1);
                fired = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid  = 1'b0;
            sum_row   = $urandom;
            carry_row = $urandom;
            drive_or();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            idle(1);
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic send_product(input logic [15:0] a, input logic [15:0] b,
                                input logic [31:0] c, input bit lat);
        logic [31:0] p;
        logic [31:0] s;
        p = 32'(a) * 32'(b);
        s = p - {c[30:0], 1'b0};
        send(s, c, p, ref_cout(s, c), lat);
    endtask

    // Monitor: compare on each handed-over result, check hold while stalled.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            mon_fire = 0;
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_output", {cout, result}, 0);
                    mon_fire = out_ready;
                end else begin
                    if (!head_seen) begin
                        head_seen = 1;
                        if (sb[0].lat) check("latency", cyc - sb[0].acc, 2);
                    end
                    if (stalled_prev) begin
                        check("stall_hold_result", result, prev_res);
                        check("stall_hold_cout", cout, prev_co);
                    end
                    if (out_ready) begin
                        check("result", result, sb[0].res);
                        check("cout", cout, sb[0].co);
                        mon_fire     = 1;
                        stalled_prev = 0;
                    end else begin
                        stalled_prev = 1;
                        prev_res     = result;
                        prev_co      = cout;
                    end
                end
            end else begin
                stalled_prev = 0;
            end
            @(posedge clk);
            if (mon_fire && rst_n && sb.size() > 0) begin
                void'(sb.pop_front());
                head_seen = 0;
            end
        end
    end

    initial begin
        int base;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sum_row   = '0;
        carry_row = '0;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_result", result, 0);
        check("reset_cout", cout, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed edge cases
        send(32'h0000_FFFF, 32'h0000_0001, 32'h0001_0001, 1'b0, 1);
        send(32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1);
        send(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1, 1);
        send(32'h0626_0060 - 32'h1579_BDE2, 32'h0ABC_DEF1, 32'h0626_0060,
             ref_cout(32'h0626_0060 - 32'h1579_BDE2, 32'h0ABC_DEF1), 1);
        drain();

        // Random products back-to-back at full throughput
        retries = 0;
        for (int i = 0; i < 1000; i++) begin
            send_product(16'($urandom), 16'($urandom), $urandom, 1);
        end
        check("full_throughput_retries", retries, 0);
        drain();

        // Raw random rows
        for (int i = 0; i < 50; i++) begin
            logic [31:0] s;
            logic [31:0] c;
            s = $urandom;
            c = $urandom;
            send(s, c, ref_value(s, c), ref_cout(s, c), 1);
        end
        drain();

        // Backpressure: out_ready low for relative cycles 3..6
        @(negedge clk);
        base       = cyc;
        stall_from = base + 3;
        stall_to   = base + 6;
        stall_on   = 1;
        saw_block  = 0;
        for (int i = 0; i < 5; i++) begin
            send_product(16'($urandom), 16'($urandom), $urandom, 0);
        end
        drain();
        check("backpressure_blocked_input", saw_block, 1);
        stall_on = 0;

        // Asynchronous reset with two transactions in flight
        hold_stall = 1;
        send_product(16'h1111, 16'h2222, 32'h1234_5678, 0);
        send_product(16'h3333, 16'h4444, 32'h0F0F_0F0F, 0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_result", result, 0);
        check("midreset_cout", cout, 0);
        check("midreset_in_ready", in_ready, 1);
        sb.delete();
        head_seen    = 0;
        stalled_prev = 0;
        hold_stall   = 0;
        out_ready    = 1'b1;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        retries = 0;
        send(32'h0000_FFFF, 32'h0000_0001, 32'h0001_0001, 1'b0, 1);
        check("first_accept_after_reset", retries, 0);
        drain();
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
